// File: rtl/kyber_params.sv
// -----------------------------------------------------------------------------
// kyber_params
// Shared constants for the ciphertext unpack stage: Kyber modulus and
// polynomial size, compression widths, group geometry, RAM base addresses
// and the unpack FSM state encoding.
// -----------------------------------------------------------------------------
package kyber_params;

  localparam int KYBER_N    = 256;
  localparam int KYBER_Q    = 3329;
  localparam int DU         = 10;
  localparam int DV         = 3;
  localparam int data_Width = 12;

  // One group is the compressed payload of one RAM word.
  localparam int GRP_W_U    = 40;  // 4 lanes x DU bits
  localparam int GRP_W_V    = 24;  // 8 lanes x DV bits
  localparam int GRP_CNT_U  = 64;  // groups per u polynomial
  localparam int GRP_CNT_V  = 32;  // groups for v

  localparam int LANES_U    = GRP_W_U / DU;
  localparam int LANES_V    = GRP_W_V / DV;

  // Groups are issued from the most significant end and written downward.
  localparam logic [6:0] BP0_BASE = 7'd63;
  localparam logic [6:0] BP1_BASE = 7'd127;
  localparam logic [4:0] V_BASE   = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BP0   = 3'd1,
    ST_BP1   = 3'd2,
    ST_V     = 3'd3,
    ST_FLUSH = 3'd4
  } state_e;

endpackage

// File: rtl/state_unpack_cit__decompress.sv
// -----------------------------------------------------------------------------
// state_unpack_cit__decompress
// Purely combinational Kyber decompression of LANES packed D-bit values:
//   y = (x*KYBER_Q + 2^(D-1)) >> D
// Ports:
//   grp_i   [D*LANES-1:0]           packed compressed lanes, lane 0 at LSB
//   coef_o  [data_Width*LANES-1:0]  decompressed coefficients, lane 0 at LSB
// -----------------------------------------------------------------------------
module state_unpack_cit__decompress
  import kyber_params::*;
#(
  parameter int D     = 10,
  parameter int LANES = 4
) (
  input  logic [D*LANES-1:0]          grp_i,
  output logic [data_Width*LANES-1:0] coef_o
);

  // x*Q + 2^(D-1) never exceeds D+12 bits, so the shifted result is 12 bits.
  localparam int PW = D + data_Width;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [PW-1:0] prod;
    assign prod = PW'(grp_i[D*j +: D]) * PW'(KYBER_Q) + PW'(1 << (D - 1));
    assign coef_o[data_Width*j +: data_Width] = prod[PW-1:D];
  end

endmodule

// File: rtl/state_unpack_cit.sv
// -----------------------------------------------------------------------------
// state_unpack_cit
// Decryption-side ciphertext unpack: walks the two compressed u polynomials
// (du=10) and the compressed v polynomial (dv=3) one group per cycle,
// decompresses every lane to 12 bits and writes the result into the Bp and V
// coefficient RAMs. Ordering mirrors the pack stage.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   enable                start pulse, only honoured in IDLE
//   i_Ciphertext0_0/_1    compressed u[0], u[1] (2560 b, held stable per run)
//   i_Ciphertext1         compressed v (768 b, held stable per run)
//   Dec_Bp_WAd/WData/We   Bp RAM write port (4 coefficients per word)
//   Dec_V_WAd/WData/We    V RAM write port (8 coefficients per word)
//   Function_done         one-cycle completion pulse
//   interrupt             sticky completion flag, only with UNPACK_INTR_EN
// Build option: define UNPACK_INTR_EN to add the interrupt output.
// -----------------------------------------------------------------------------
module state_unpack_cit
  import kyber_params::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [2559:0] i_Ciphertext0_0,
  input  logic [2559:0] i_Ciphertext0_1,
  input  logic [767:0]  i_Ciphertext1,
  output logic [6:0]    Dec_Bp_WAd,
  output logic [47:0]   Dec_Bp_WData,
  output logic          Dec_Bp_We,
  output logic [4:0]    Dec_V_WAd,
  output logic [95:0]   Dec_V_WData,
  output logic          Dec_V_We,
  output logic          Function_done
`ifdef UNPACK_INTR_EN
  ,
  output logic          interrupt
`endif
);

  state_e       state_q, state_d;
  logic [5:0]   grp_q, grp_d;
  logic [6:0]   bp_wad_q, bp_wad_d;
  logic [47:0]  bp_wdata_q, bp_wdata_d;
  logic         bp_we_q, bp_we_d;
  logic [4:0]   v_wad_q, v_wad_d;
  logic [95:0]  v_wdata_q, v_wdata_d;
  logic         v_we_q, v_we_d;
  logic         done_q, done_d;

  // ---------------------------------------------------------------------------
  // Group selection. Group g sits at the top of the vector minus g groups, so
  // its LSB offset is width*(count-1-g); for a power-of-two count that is ~g.
  // ---------------------------------------------------------------------------
  logic [2559:0] u_src;
  logic [11:0]   u_base;
  logic [9:0]    v_base;
  logic [39:0]   u_grp;
  logic [23:0]   v_grp;
  logic [47:0]   u_coef;
  logic [95:0]   v_coef;

  assign u_src  = (state_q == ST_BP1) ? i_Ciphertext0_1 : i_Ciphertext0_0;
  assign u_base = {6'd0, ~grp_q} * 12'(GRP_W_U);
  assign v_base = {5'd0, ~grp_q[4:0]} * 10'(GRP_W_V);
  assign u_grp  = u_src[u_base +: GRP_W_U];
  assign v_grp  = i_Ciphertext1[v_base +: GRP_W_V];

  state_unpack_cit__decompress #(.D(DU), .LANES(LANES_U)) u_dec_u (
    .grp_i  (u_grp),
    .coef_o (u_coef)
  );

  state_unpack_cit__decompress #(.D(DV), .LANES(LANES_V)) u_dec_v (
    .grp_i  (v_grp),
    .coef_o (v_coef)
  );

  // ---------------------------------------------------------------------------
  // Next-state and output-register logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    grp_d      = grp_q;
    bp_wad_d   = bp_wad_q;
    bp_wdata_d = bp_wdata_q;
    bp_we_d    = 1'b0;
    v_wad_d    = v_wad_q;
    v_wdata_d  = v_wdata_q;
    v_we_d     = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_BP0;
          grp_d   = '0;
        end
      end

      ST_BP0, ST_BP1: begin
        bp_we_d    = 1'b1;
        bp_wad_d   = ((state_q == ST_BP0) ? BP0_BASE : BP1_BASE) - {1'b0, grp_q};
        bp_wdata_d = u_coef;
        grp_d      = grp_q + 6'd1;
        if (grp_q == 6'(GRP_CNT_U - 1)) begin
          state_d = (state_q == ST_BP0) ? ST_BP1 : ST_V;
          grp_d   = '0;
        end
      end

      ST_V: begin
        v_we_d    = 1'b1;
        v_wad_d   = V_BASE - grp_q[4:0];
        v_wdata_d = v_coef;
        grp_d     = grp_q + 6'd1;
        if (grp_q == 6'(GRP_CNT_V - 1)) begin
          state_d = ST_FLUSH;
          grp_d   = '0;
        end
      end

      // Last V word is being registered this cycle; signal completion next.
      ST_FLUSH: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so all
      // flops sample the pre-edge values, independent of statement order.
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp_q      <= '0;
      bp_wad_q   <= '0;
      bp_wdata_q <= '0;
      bp_we_q    <= 1'b0;
      v_wad_q    <= '0;
      v_wdata_q  <= '0;
      v_we_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      grp_q      <= grp_d;
      bp_wad_q   <= bp_wad_d;
      bp_wdata_q <= bp_wdata_d;
      bp_we_q    <= bp_we_d;
      v_wad_q    <= v_wad_d;
      v_wdata_q  <= v_wdata_d;
      v_we_q     <= v_we_d;
      done_q     <= done_d;
    end
  end

  assign Dec_Bp_WAd    = bp_wad_q;
  assign Dec_Bp_WData  = bp_wdata_q;
  assign Dec_Bp_We     = bp_we_q;
  assign Dec_V_WAd     = v_wad_q;
  assign Dec_V_WData   = v_wdata_q;
  assign Dec_V_We      = v_we_q;
  assign Function_done = done_q;

`ifdef UNPACK_INTR_EN
  // Sticky completion flag: set with Function_done, cleared by the next start.
  logic intr_q, intr_d;

  always_comb begin
    intr_d = intr_q;
    if (state_q == ST_IDLE && enable) begin
      intr_d = 1'b0;
    end else if (done_d) begin
      intr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      intr_q <= 1'b0;
    end else begin
      intr_q <= intr_d;
    end
  end

  assign interrupt = intr_q;
`endif

endmodule
